// File: rtl/pocket_brg_slave.sv
// SPI-style bridge slave: decodes a 2-lane serial frame into one bus write or one bus read,
// and shifts read data (or a fallback word on timeout) back to the host.
module pocket_brg_slave #(
   parameter int          RD_TIMEOUT  = 24,
   parameter logic [31:0] RD_FALLBACK = 32'hFFFF_FFFF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_brg_spiclk,
   input  logic        i_brg_spiss,
   input  logic        i_brg_spimosi_in,
   input  logic        i_brg_spimiso_in,
   output logic        o_brg_spimosi_out,
   output logic        o_brg_spimiso_out,
   output logic        o_brg_spi_oe,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_dout,
   output logic        o_bus_wr,
   output logic        o_bus_rd,
   input  logic [31:0] i_bus_din,
   input  logic        i_bus_rdy,
   output logic        o_rd_tout
);

   // state | meaning
   // IDLE  | waiting for chip-select fall (only once ss has been seen high)
   // ADDR  | shifting in the 32-bit address word
   // WDATA | shifting in the 32-bit write word
   // RWAIT | bus read issued, waiting for bus_rdy / timeout / first SPI fall
   // RDATA | presenting read bits on each SPI fall
   // DONE  | frame complete, waiting for ss rise
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_DONE} state_t;

   localparam int TW = $clog2(RD_TIMEOUT + 1);

   state_t          r_state, w_state_nxt;
   logic [1:0]      r_sclk_sync, r_ss_sync, r_mosi_sync, r_miso_sync;
   logic            r_sclk_d, r_ss_d;
   logic [1:0]      r_vld;
   logic            r_armed;
   logic [4:0]      r_cnt;
   logic [31:2]     r_shift;
   logic [31:1]     r_addr;
   logic [31:0]     r_rdat;
   logic [TW-1:0]   r_tmr;

   logic        w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
   logic [31:0] w_word;
   logic        w_shift, w_cnt_clr, w_addr_done, w_wr_go, w_rd_latch;
   logic        w_fb_fall, w_tout, w_present, w_release;

   assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
   assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
   assign w_ss_rise   = r_ss_sync[1] & ~r_ss_d;
   assign w_ss_fall   = ~r_ss_sync[1] & r_ss_d;
   assign w_word      = {r_miso_sync[1], r_mosi_sync[1], r_shift[31:2]};

   always_comb begin
      w_state_nxt = r_state;
      w_shift     = 1'b0;
      w_cnt_clr   = 1'b0;
      w_addr_done = 1'b0;
      w_wr_go     = 1'b0;
      w_rd_latch  = 1'b0;
      w_fb_fall   = 1'b0;
      w_tout      = 1'b0;
      w_present   = 1'b0;
      w_release   = 1'b0;
      if (r_state != S_IDLE && w_ss_rise) begin
         w_state_nxt = S_IDLE;
         w_release   = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: if (w_ss_fall && r_armed) begin
               w_state_nxt = S_ADDR;
               w_cnt_clr   = 1'b1;
            end
            S_ADDR: if (w_sclk_rise) begin
               w_shift = 1'b1;
               if (r_cnt == 5'd15) begin
                  w_addr_done = 1'b1;
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = w_word[0] ? S_WDATA : S_RWAIT;
               end
            end
            S_WDATA: if (w_sclk_rise) begin
               w_shift = 1'b1;
               if (r_cnt == 5'd15) begin
                  w_wr_go     = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
            S_RWAIT: begin
               if (i_bus_rdy) begin
                  w_rd_latch  = 1'b1;
                  w_state_nxt = S_RDATA;
               end else if (w_sclk_fall) begin
                  // host already clocking out: this fall is read slot 0
                  w_fb_fall   = 1'b1;
                  w_state_nxt = S_RDATA;
               end else if (r_tmr == TW'(1)) begin
                  w_tout      = 1'b1;
                  w_state_nxt = S_RDATA;
               end
            end
            S_RDATA: if (w_sclk_fall) begin
               if (r_cnt == 5'd16) begin
                  w_release   = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_present = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state           <= S_IDLE;
         r_sclk_sync       <= 2'b00;
         r_ss_sync         <= 2'b11;
         r_mosi_sync       <= 2'b00;
         r_miso_sync       <= 2'b00;
         r_sclk_d          <= 1'b0;
         r_ss_d            <= 1'b1;
         r_vld             <= 2'b00;
         r_armed           <= 1'b0;
         r_cnt             <= '0;
         r_shift           <= '0;
         r_addr            <= '0;
         r_rdat            <= '0;
         r_tmr             <= '0;
         o_brg_spimosi_out <= 1'b0;
         o_brg_spimiso_out <= 1'b0;
         o_brg_spi_oe      <= 1'b0;
         o_bus_addr        <= '0;
         o_bus_dout        <= '0;
         o_bus_wr          <= 1'b0;
         o_bus_rd          <= 1'b0;
         o_rd_tout         <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sclk_sync <= {r_sclk_sync[0], i_brg_spiclk};
         r_ss_sync   <= {r_ss_sync[0], i_brg_spiss};
         r_mosi_sync <= {r_mosi_sync[0], i_brg_spimosi_in};
         r_miso_sync <= {r_miso_sync[0], i_brg_spimiso_in};
         r_sclk_d    <= r_sclk_sync[1];
         r_ss_d      <= r_ss_sync[1];
         // frames only start after a genuinely sampled ss-high following reset
         r_vld       <= {r_vld[0], 1'b1};
         r_armed     <= r_armed | (r_vld[1] & r_ss_sync[1]);
         o_bus_wr    <= 1'b0;
         o_bus_rd    <= 1'b0;
         o_rd_tout   <= 1'b0;

         if (w_cnt_clr)
            r_cnt <= '0;
         else if (w_shift || w_present || w_fb_fall)
            r_cnt <= r_cnt + 5'd1;
         if (w_shift)
            r_shift <= w_word[31:2];

         if (w_addr_done) begin
            r_addr <= w_word[31:1];
            if (!w_word[0]) begin
               o_bus_rd   <= 1'b1;
               o_bus_addr <= {w_word[31:1], 1'b0};
               r_tmr      <= TW'(RD_TIMEOUT);
            end
         end else if (r_tmr != '0) begin
            r_tmr <= r_tmr - TW'(1);
         end

         if (w_wr_go) begin
            o_bus_wr   <= 1'b1;
            o_bus_addr <= {r_addr, 1'b0};
            o_bus_dout <= w_word;
         end
         if (w_rd_latch)
            r_rdat <= i_bus_din;
         if (w_tout) begin
            r_rdat    <= RD_FALLBACK;
            o_rd_tout <= 1'b1;
         end
         if (w_fb_fall) begin
            {o_brg_spimiso_out, o_brg_spimosi_out} <= RD_FALLBACK[1:0];
            r_rdat       <= RD_FALLBACK >> 2;
            o_rd_tout    <= 1'b1;
            o_brg_spi_oe <= 1'b1;
         end
         if (w_present) begin
            {o_brg_spimiso_out, o_brg_spimosi_out} <= r_rdat[1:0];
            r_rdat       <= r_rdat >> 2;
            o_brg_spi_oe <= 1'b1;
         end
         if (w_release) begin
            {o_brg_spimiso_out, o_brg_spimosi_out} <= 2'b00;
            o_brg_spi_oe <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pocket_brg_slave.sv
// Bench for pocket_brg_slave: a host model drives serial frames, a bus responder answers reads,
// and each frame's bus activity and read-back word are compared with what the frame should do.
module tb_pocket_brg_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        ss = 1'b1;
   logic        mosi_in = 1'b0;
   logic        miso_in = 1'b0;
   logic        mosi_out, miso_out, spi_oe;
   logic [31:0] bus_addr, bus_dout;
   logic        bus_wr, bus_rd, rd_tout;
   logic [31:0] bus_din;
   logic        bus_rdy;

   int          n_checks = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          wr_cnt = 0, rd_cnt = 0, tout_cnt = 0;
   int          rd_cyc = 0, tout_cyc = 0;
   logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
   int          rdy_dly = -1;
   int          rsp_cnt = -1;
   logic [31:0] rsp_data = '0;
   bit          noise_en = 1'b0;

   localparam int GAP = 1000;

   pocket_brg_slave dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_brg_spiclk      (sclk),
      .i_brg_spiss       (ss),
      .i_brg_spimosi_in  (mosi_in),
      .i_brg_spimiso_in  (miso_in),
      .o_brg_spimosi_out (mosi_out),
      .o_brg_spimiso_out (miso_out),
      .o_brg_spi_oe      (spi_oe),
      .o_bus_addr        (bus_addr),
      .o_bus_dout        (bus_dout),
      .o_bus_wr          (bus_wr),
      .o_bus_rd          (bus_rd),
      .i_bus_din         (bus_din),
      .i_bus_rdy         (bus_rdy),
      .o_rd_tout         (rd_tout)
   );

   always #7 clk = ~clk;

   // bus monitor and read responder, sampled mid-cycle
   always @(negedge clk) begin
      cyc++;
      if (bus_wr) begin
         wr_cnt++;
         wr_addr = bus_addr;
         wr_data = bus_dout;
      end
      if (bus_rd) begin
         rd_cnt++;
         rd_addr = bus_addr;
         rd_cyc  = cyc;
      end
      if (rd_tout) begin
         tout_cnt++;
         tout_cyc = cyc;
      end
      bus_rdy = 1'b0;
      if (bus_rd && rdy_dly >= 0)
         rsp_cnt = rdy_dly;
      else if (rsp_cnt > 0)
         rsp_cnt--;
      if (rsp_cnt == 0) begin
         bus_rdy = 1'b1;
         bus_din = rsp_data;
         rsp_cnt = -1;
      end else if (noise_en) begin
         bus_rdy = 1'($urandom_range(0, 1));
         bus_din = $urandom;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic spi_pair(input logic [1:0] b, input int half, output logic [1:0] r);
      {miso_in, mosi_in} = b;
      #(half);
      sclk = 1'b1;
      r = {miso_out, mosi_out};
      #(half);
      sclk = 1'b0;
   endtask

   // full frame; abort_at < 16 raises ss after that many address pairs
   task automatic spi_frame(input logic [31:0] addr, input logic [31:0] wdata, input int half,
                            input int abort_at, output logic [31:0] rdata);
      logic [1:0] r;
      rdata = '0;
      ss = 1'b0;
      #(half);
      for (int k = 0; k < 16; k++) begin
         if (k == abort_at) begin
            ss = 1'b1;
            #(GAP);
            return;
         end
         spi_pair(addr[2*k +: 2], half, r);
      end
      for (int k = 0; k < 16; k++) begin
         spi_pair(addr[0] ? wdata[2*k +: 2] : 2'b00, half, r);
         rdata[2*k +: 2] = r;
         if (!addr[0] && k == 0)
            chk("oe_high_in_read", {31'd0, spi_oe}, 32'd1);
      end
      #(half);
      if (!addr[0])
         chk("oe_low_after_read", {31'd0, spi_oe}, 32'd0);
      ss = 1'b1;
      #(GAP);
   endtask

   task automatic run_frame(input logic [31:0] addr, input logic [31:0] wdata, input int half,
                            input int dly, input logic [31:0] din);
      int          wr0, rd0, to0;
      logic [31:0] rdata, exp_rd;
      wr0 = wr_cnt; rd0 = rd_cnt; to0 = tout_cnt;
      rdy_dly  = dly;
      rsp_data = din;
      noise_en = addr[0];
      spi_frame(addr, wdata, half, 16, rdata);
      noise_en = 1'b0;
      if (addr[0]) begin
         chk("wr_count", wr_cnt - wr0, 1);
         chk("rd_count_wr", rd_cnt - rd0, 0);
         chk("wr_addr", wr_addr, addr & 32'hFFFF_FFFE);
         chk("wr_data", wr_data, wdata);
         chk("dout_hold", bus_dout, wdata);
      end else begin
         exp_rd = (dly >= 0) ? din : 32'hFFFF_FFFF;
         chk("rd_count", rd_cnt - rd0, 1);
         chk("wr_count_rd", wr_cnt - wr0, 0);
         chk("rd_addr", rd_addr, addr & 32'hFFFF_FFFE);
         chk("rd_data", rdata, exp_rd);
         chk("tout_count", tout_cnt - to0, (dly >= 0) ? 0 : 1);
      end
   endtask

   initial begin
      logic [31:0] a, d, rdata;
      logic [1:0]  r;
      int          wr0, rd0, half, dly;

      repeat (5) @(negedge clk);
      chk("rst_addr", bus_addr, 0);
      chk("rst_dout", bus_dout, 0);
      chk("rst_strobes", {29'd0, bus_wr, bus_rd, rd_tout}, 0);
      chk("rst_lanes", {29'd0, spi_oe, miso_out, mosi_out}, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      run_frame(32'h0000_0011, 32'hCAFE_1234, 500, -1, 0);
      chk("wr_addr_bit0", bus_addr, 32'h0000_0010);

      run_frame(32'h0000_0020, 0, 500, 3, 32'h8765_4321);

      run_frame(32'h0000_0040, 0, 500, -1, 0);
      chk("tout_latency", tout_cyc - rd_cyc, 24);

      // host at 4 MHz outruns the timeout: fallback starts on the first fall
      run_frame(32'h0000_0044, 0, 125, -1, 0);

      wr0 = wr_cnt; rd0 = rd_cnt;
      spi_frame(32'h0000_0080, 0, 500, 10, rdata);
      chk("abort_no_rd", rd_cnt - rd0, 0);
      chk("abort_no_wr", wr_cnt - wr0, 0);
      chk("abort_oe", {31'd0, spi_oe}, 0);
      run_frame(32'h0000_1235, 32'h0BAD_F00D, 500, -1, 0);

      // reset during write data with ss held low
      wr0 = wr_cnt;
      a = 32'h0000_0031;
      d = 32'h1357_9BDF;
      ss = 1'b0;
      #(500);
      for (int k = 0; k < 16; k++) spi_pair(a[2*k +: 2], 500, r);
      for (int k = 0; k < 5; k++) spi_pair(d[2*k +: 2], 500, r);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("midrst_addr", bus_addr, 0);
      for (int k = 5; k < 16; k++) spi_pair(d[2*k +: 2], 500, r);
      #(500);
      chk("midrst_no_wr", wr_cnt - wr0, 0);
      ss = 1'b1;
      #(GAP);
      run_frame(32'h0000_0055, 32'h2468_ACE0, 500, -1, 0);

      // status read then write, ss high only GAP between them
      run_frame(32'hF800_0000, 0, 500, 2, 32'h0000_00A5);
      run_frame(32'h0000_0201, 32'h5A5A_A5A5, 500, -1, 0);
      chk("b2b_addr", bus_addr, 32'h0000_0200);

      for (int i = 0; i < 8; i++) begin
         a    = $urandom;
         d    = $urandom;
         half = ($urandom_range(0, 1) != 0) ? 300 : 200;
         dly  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 8));
         run_frame(a, d, half, dly, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
